stripe_sequencer: RTL and testbench

- Upstream controller for PE_array_64: sequences a full alignment of query A (2-bit bases, up to A_LEN) against reference B, split into 64-base stripes.
- Per stripe: fetches one 128-bit B word, holds it on the array's i_B, streams A bases from the current start position with i_start, and reacts to o_stripe_end.
- Carries the start position from stripe to stripe and tracks the best stripe score; reports per-stripe results and a final done.

---
 rtl/stripe_sequencer.sv | 177 +++++++++++++++++
 tb/tb_stripe_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stripe_sequencer.sv
// Stripe sequencer for a 64-PE systolic alignment array: loads one B word per stripe, streams A
// from the carried start position, and tracks per-stripe and best scores across the run.
module stripe_sequencer #(
  parameter int unsigned A_LEN    = 1024,
  parameter int unsigned A_AW     = 10,
  parameter int unsigned NUM_PE   = 64,
  parameter int unsigned SCORE_W  = 14,
  parameter int unsigned STRIPE_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_go,
  input  logic [STRIPE_W:0]     i_num_stripes,
  output logic [STRIPE_W-1:0]   o_b_addr,
  input  logic [2*NUM_PE-1:0]   i_b_rdata,
  output logic [A_AW-1:0]       o_a_addr,
  input  logic [1:0]            i_a_rdata,
  output logic                  o_pe_start,
  output logic [2*NUM_PE-1:0]   o_pe_B,
  output logic [1:0]            o_pe_A,
  input  logic                  i_stripe_end,
  input  logic [A_AW-1:0]       i_start_position,
  input  logic [SCORE_W-1:0]    i_max_score_stripe,
  output logic                  o_busy,
  output logic                  o_stripe_done,
  output logic [STRIPE_W-1:0]   o_stripe_idx,
  output logic [SCORE_W-1:0]    o_stripe_score,
  output logic [SCORE_W-1:0]    o_best_score,
  output logic [STRIPE_W-1:0]   o_best_stripe,
  output logic                  o_done
);

  localparam logic [A_AW-1:0] A_LAST  = A_AW'(A_LEN - 1);
  localparam logic [A_AW:0]   A_LIMIT = (A_AW + 1)'(A_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StWaitB,
    StGap,
    StStream,
    StDrain,
    StNext,
    StFin
  } state_e;

  state_e                state_q, state_d;
  logic [STRIPE_W:0]     num_q;
  logic [STRIPE_W-1:0]   k_q;
  logic [A_AW-1:0]       start_pos_q;
  logic [A_AW-1:0]       j_q;
  logic [2*NUM_PE-1:0]   pe_b_q;
  logic                  pe_start_q;
  logic [SCORE_W-1:0]    best_score_q;
  logic [STRIPE_W-1:0]   best_stripe_q;
  logic                  exhausted_q;
  logic                  zero_done_q;

  logic [A_AW:0]         sum;
  logic                  last_stripe;
  logic                  overflow;

  // Next stripe start, one bit wider so running off the end of A is visible.
  assign sum         = {1'b0, start_pos_q} + {1'b0, i_start_position} + (A_AW + 1)'(1);
  assign overflow    = (sum >= A_LIMIT);
  assign last_stripe = (({1'b0, k_q} + (STRIPE_W + 1)'(1)) == num_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_go && (i_num_stripes != '0)) state_d = StLoadB;
      StLoadB:  state_d = StWaitB;
      StWaitB:  state_d = StGap;
      StGap:    state_d = StStream;
      StStream: begin
        if (i_stripe_end) begin
          state_d = StNext;
        end else if (j_q == A_LAST) begin
          state_d = StDrain;
        end
      end
      StDrain:  if (i_stripe_end) state_d = StNext;
      StNext:   state_d = (last_stripe || exhausted_q || overflow) ? StFin : StLoadB;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_q         <= '0;
      k_q           <= '0;
      start_pos_q   <= '0;
      j_q           <= '0;
      pe_b_q        <= '0;
      pe_start_q    <= 1'b0;
      best_score_q  <= '0;
      best_stripe_q <= '0;
      exhausted_q   <= 1'b0;
      zero_done_q   <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      // Start follows the address by one cycle so it lines up with the A read data.
      pe_start_q  <= (state_q == StStream) && !i_stripe_end;
      case (state_q)
        StIdle: begin
          if (i_go) begin
            num_q         <= i_num_stripes;
            k_q           <= '0;
            start_pos_q   <= '0;
            best_score_q  <= '0;
            best_stripe_q <= '0;
            exhausted_q   <= 1'b0;
            zero_done_q   <= (i_num_stripes == '0);
          end
        end
        StWaitB: pe_b_q <= i_b_rdata;
        StGap:   j_q <= start_pos_q;
        StStream: begin
          if (!i_stripe_end) begin
            if (j_q == A_LAST) begin
              exhausted_q <= 1'b1;
            end else begin
              j_q <= j_q + A_AW'(1);
            end
          end
        end
        StNext: begin
          // Strictly greater: a tie keeps the earlier stripe.
          if (i_max_score_stripe > best_score_q) begin
            best_score_q  <= i_max_score_stripe;
            best_stripe_q <= k_q;
          end
          start_pos_q <= sum[A_AW-1:0];
          k_q         <= k_q + STRIPE_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy         = 1'b0;
    o_stripe_done  = 1'b0;
    o_stripe_idx   = '0;
    o_stripe_score = '0;
    o_done         = zero_done_q;
    unique case (state_q)
      StIdle: ;
      StNext: begin
        o_busy         = 1'b1;
        o_stripe_done  = 1'b1;
        o_stripe_idx   = k_q;
        o_stripe_score = i_max_score_stripe;
      end
      StFin:   o_done = 1'b1;
      default: o_busy = 1'b1;
    endcase
  end

  assign o_b_addr      = k_q;
  assign o_a_addr      = j_q;
  assign o_pe_start    = pe_start_q;
  assign o_pe_B        = pe_b_q;
  assign o_pe_A        = i_a_rdata;
  assign o_best_score  = best_score_q;
  assign o_best_stripe = best_stripe_q;

endmodule

// File: tb/tb_stripe_sequencer.sv
// Bench for stripe_sequencer: memory and PE models plus a run-level expectation model; the
// monitor compares DUT outputs against that model every cycle.
module tb_stripe_sequencer;

  localparam int A_LEN = 1024;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_go = 1'b0;
  logic [4:0]   i_num_stripes = '0;
  logic [3:0]   o_b_addr;
  logic [127:0] b_rdata = '0;
  logic [9:0]   o_a_addr;
  logic [1:0]   a_rdata = '0;
  logic         o_pe_start;
  logic [127:0] o_pe_B;
  logic [1:0]   o_pe_A;
  logic         i_stripe_end = 1'b0;
  logic [9:0]   i_start_position = '0;
  logic [13:0]  i_max_score_stripe = '0;
  logic         o_busy, o_stripe_done, o_done;
  logic [3:0]   o_stripe_idx, o_best_stripe;
  logic [13:0]  o_stripe_score, o_best_score;

  stripe_sequencer dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_go               (i_go),
    .i_num_stripes      (i_num_stripes),
    .o_b_addr           (o_b_addr),
    .i_b_rdata          (b_rdata),
    .o_a_addr           (o_a_addr),
    .i_a_rdata          (a_rdata),
    .o_pe_start         (o_pe_start),
    .o_pe_B             (o_pe_B),
    .o_pe_A             (o_pe_A),
    .i_stripe_end       (i_stripe_end),
    .i_start_position   (i_start_position),
    .i_max_score_stripe (i_max_score_stripe),
    .o_busy             (o_busy),
    .o_stripe_done      (o_stripe_done),
    .o_stripe_idx       (o_stripe_idx),
    .o_stripe_score     (o_stripe_score),
    .o_best_score       (o_best_score),
    .o_best_stripe      (o_best_stripe),
    .o_done             (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Stripe table (PE behaviour per stripe) and model expectations.
  int tab_ea[16];
  int tab_pos[16];
  int tab_scr[16];
  int exp_start[16];
  int exp_nstarts[16];
  int exp_n, exp_best, exp_bestk;
  int run_seq = 0;

  // Monitor / PE model state.
  int seen_seq = 0;
  int done_cnt = 0;
  int done_events = 0;
  int pe_idx = 0;
  int cnt = 0;
  int idle = 0;
  int last_cnt = 0;
  int b_age = 0;
  bit ended = 0;
  bit fire = 0;
  bit end_now = 0;
  logic [127:0] prev_b = '0;

  function automatic logic [127:0] bword(input int r, input int a);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(r) * 32'h100 + 32'(a);
    return {w, ~w, w ^ 32'h0F0F_0F0F, w + 32'd7};
  endfunction

  function automatic logic [1:0] abase(input int a);
    return 2'(a ^ (a >> 2) ^ (a >> 5));
  endfunction

  // Synchronous memories: data one cycle after the address.
  always @(posedge clk) begin
    b_rdata <= bword(run_seq, int'(o_b_addr));
    a_rdata <= abase(int'(o_a_addr));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_tab(input int k, input int ea, input int pos, input int scr);
    tab_ea[k]  = ea;
    tab_pos[k] = pos;
    tab_scr[k] = scr;
  endtask

  // Run-level model: where each stripe starts, how many A bases it consumes, and the best.
  task automatic model(input int num);
    int s;
    int sum;
    bit exh;
    s = 0;
    exp_n = 0;
    exp_best = 0;
    exp_bestk = 0;
    for (int k = 0; k < num; k++) begin
      exp_start[k] = s;
      exh = (tab_ea[k] == 0) || (s + tab_ea[k] >= A_LEN - 1);
      exp_nstarts[k] = (tab_ea[k] == 0 || tab_ea[k] > A_LEN - s) ? A_LEN - s : tab_ea[k];
      if (tab_scr[k] > exp_best) begin
        exp_best  = tab_scr[k];
        exp_bestk = k;
      end
      exp_n++;
      sum = s + tab_pos[k] + 1;
      if (exh || sum >= A_LEN) break;
      s = sum;
    end
  endtask

  always @(negedge clk) begin
    if (run_seq != seen_seq) begin
      seen_seq = run_seq;
      done_cnt = 0;
      pe_idx = 0;
      cnt = 0;
      idle = 0;
      ended = 0;
      fire = 0;
    end
    if (o_pe_B != prev_b) b_age = 0;
    else b_age++;
    prev_b = o_pe_B;
    if (i_rst) begin
      pe_idx = 0;
      cnt = 0;
      idle = 0;
      ended = 0;
      fire = 0;
      i_stripe_end = 1'b0;
    end else begin
      i_start_position   = 10'(tab_pos[pe_idx]);
      i_max_score_stripe = 14'(tab_scr[pe_idx]);
      if (o_stripe_done) begin
        chk("stripe_in_range", 1'(done_cnt < exp_n), 1'b1);
        chk("stripe_idx", o_stripe_idx, 4'(done_cnt));
        chk("stripe_score", o_stripe_score, 14'(tab_scr[done_cnt]));
        chk("stripe_starts", last_cnt, exp_nstarts[done_cnt]);
        chk("stripe_busy", o_busy, 1'b1);
        done_cnt++;
      end
      if (o_done) begin
        chk("done_stripes", done_cnt, exp_n);
        chk("done_best_score", o_best_score, 14'(exp_best));
        chk("done_best_stripe", o_best_stripe, 4'(exp_bestk));
        chk("done_busy", o_busy, 1'b0);
        done_events++;
      end
      end_now = fire;
      fire = 0;
      i_stripe_end = end_now;
      if (end_now) begin
        ended = 1;
        last_cnt = cnt;
      end else if (ended) begin
        if (!o_pe_start) begin
          ended = 0;
          cnt = 0;
          idle = 0;
          pe_idx++;
        end
      end else if (o_pe_start) begin
        if (cnt == 0) begin
          chk("b_word", o_pe_B, bword(run_seq, pe_idx));
          chk("b_gap", b_age, 2);
        end
        chk("a_base", o_pe_A, abase(exp_start[pe_idx] + cnt));
        cnt++;
        idle = 0;
        if (cnt == tab_ea[pe_idx]) fire = 1;
      end else if (cnt > 0) begin
        // A ran out before the PE finished: it reports the end a few cycles later.
        idle++;
        if (idle == 3) fire = 1;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_sdone"}, o_stripe_done, 1'b0);
    chk({tag, "_sidx"}, o_stripe_idx, 4'd0);
    chk({tag, "_sscore"}, o_stripe_score, 14'd0);
    chk({tag, "_baddr"}, o_b_addr, 4'd0);
    chk({tag, "_aaddr"}, o_a_addr, 10'd0);
    chk({tag, "_start"}, o_pe_start, 1'b0);
    chk({tag, "_peb"}, o_pe_B, 128'd0);
    chk({tag, "_best"}, o_best_score, 14'd0);
    chk({tag, "_bstripe"}, o_best_stripe, 4'd0);
  endtask

  task automatic run(input int num, input bit poke);
    int d0;
    run_seq++;
    model(num);
    d0 = done_events;
    i_num_stripes = 5'(num);
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    if (num == 0) chk("zero_done_next", o_done, 1'b1);
    if (poke) begin
      repeat (20) @(negedge clk);
      chk("poke_busy", o_busy, 1'b1);
      i_num_stripes = 5'd1;
      i_go = 1'b1;
      @(negedge clk);
      i_go = 1'b0;
    end
    for (int i = 0; i < 4000 && done_events == d0; i++) @(negedge clk);
    chk("done_seen", done_events - d0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) set_tab(k, 4, 0, 0);
    repeat (3) @(negedge clk);
    check_zero("por");
    i_rst = 1'b0;
    @(negedge clk);

    set_tab(0, 10, 5, 100);
    run(1, 1'b0);
    chk("single_best", o_best_score, 14'd100);
    chk("single_bstripe", o_best_stripe, 4'd0);

    set_tab(0, 6, 5, 50);
    set_tab(1, 8, 7, 120);
    set_tab(2, 4, 3, 120);
    run(3, 1'b1);
    chk("three_model_start1", exp_start[1], 6);
    chk("three_model_start2", exp_start[2], 14);
    chk("three_best", o_best_score, 14'd120);
    chk("three_bstripe", o_best_stripe, 4'd1);

    set_tab(0, 3, 1019, 7);
    set_tab(1, 0, 2, 9);
    set_tab(2, 4, 1, 60);
    set_tab(3, 4, 1, 70);
    run(4, 1'b0);
    chk("exh_stripes", done_cnt, 2);
    chk("exh_model_start1", exp_start[1], 1020);
    chk("exh_best", o_best_score, 14'd9);

    set_tab(0, 4, 999, 30);
    set_tab(1, 5, 30, 20);
    set_tab(2, 4, 1, 90);
    run(3, 1'b0);
    chk("ovf_stripes", done_cnt, 2);
    chk("ovf_best", o_best_score, 14'd30);
    chk("ovf_bstripe", o_best_stripe, 4'd0);

    run(0, 1'b0);
    chk("zero_best", o_best_score, 14'd0);

    // Reset in the middle of streaming.
    set_tab(0, 20, 3, 40);
    set_tab(1, 20, 3, 50);
    run_seq++;
    model(2);
    i_num_stripes = 5'd2;
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    for (int i = 0; i < 50 && !o_pe_start; i++) @(negedge clk);
    chk("rst_reach_stream", o_pe_start, 1'b1);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst");
    i_rst = 1'b0;
    @(negedge clk);

    set_tab(0, 10, 5, 100);
    run(1, 1'b0);
    chk("post_rst_best", o_best_score, 14'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
